// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores on a req/ack port, bypasses results to execute
// and registers the retiring entry. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int MEM_ENTRY_SIZE = 320,
    parameter int RET_ENTRY_SIZE = 320,
    parameter int WAIT_CNT_W     = 16
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic [MEM_ENTRY_SIZE-1:0] mem_entry,
    input  logic                      flush_fCOM,
    input  logic                      dmem_ack,
    input  logic [31:0]               dmem_rdata,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [31:0]               dmem_addr,
    output logic [3:0]                dmem_be,
    output logic [31:0]               dmem_wdata,
    output logic                      stall_MEM,
    output logic                      do_writeback1_MEM,
    output logic [5:0]                writeRegister1_MEM,
    output logic [31:0]               Data1_MEM,
    output logic [RET_ENTRY_SIZE-1:0] ret_entry,
    output logic [WAIT_CNT_W-1:0]     wait_cycles,
    output logic                      misalign_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t                    state;
    logic [MEM_ENTRY_SIZE-1:0] lat_entry;
    logic [MEM_ENTRY_SIZE-1:0] cur;
    logic [MEM_ENTRY_SIZE-1:0] done_entry;
    logic [MEM_ENTRY_SIZE-1:0] trap_entry;
    logic [31:0]               addr;
    logic [31:0]               st_data;
    logic [1:0]                size;
    logic                      is_mem;
    logic                      is_load;
    logic                      mis;
    logic                      ack_hit;
    logic [7:0]                ld_byte;
    logic [15:0]               ld_half;
    logic [31:0]               ld_ext;

    // While a transaction is outstanding the latched copy, not the live input, owns the port.
    always_comb begin
        // NOTE: every always_comb target gets a default first so no latch can be inferred.
        cur        = (state == S_IDLE) ? mem_entry : lat_entry;
        addr       = cur[223:192];
        st_data    = cur[287:256];
        size       = cur[136:135];
        is_mem     = cur[139] | cur[138];
        is_load    = cur[139] & ~cur[138];
`ifdef MEM_MISALIGN_TRAP_EN
        mis = (state == S_IDLE) && is_mem &&
              (((size == 2'b01) && addr[0]) ||
               (((size == 2'b00) || (size == 2'b11)) && (addr[1:0] != 2'b00)));
`else
        mis = 1'b0;
`endif

        case (addr[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (size)
            2'b10:   ld_ext = cur[134] ? {{24{ld_byte[7]}}, ld_byte} : {24'd0, ld_byte};
            2'b01:   ld_ext = cur[134] ? {{16{ld_half[15]}}, ld_half} : {16'd0, ld_half};
            default: ld_ext = dmem_rdata;
        endcase

        done_entry = cur;
        if (is_load) done_entry[223:192] = ld_ext;
        trap_entry      = cur;
        trap_entry[141] = 1'b1;

        dmem_req           = 1'b0;
        dmem_we            = 1'b0;
        dmem_addr          = 32'd0;
        dmem_be            = 4'd0;
        dmem_wdata         = 32'd0;
        stall_MEM          = 1'b0;
        do_writeback1_MEM  = 1'b0;
        writeRegister1_MEM = 6'd0;
        Data1_MEM          = 32'd0;
        ack_hit            = 1'b0;

        // Combinational outputs are forced low while RESET is asserted so an abandoned
        // request drops at once, even though upstream still presents the memory op.
        if (RESET) begin
            dmem_req = (state != S_IDLE) || (is_mem && !flush_fCOM && !mis);
            if (dmem_req) begin
                dmem_we   = cur[138];
                dmem_addr = {addr[31:2], 2'b00};
                case (size)
                    2'b10: begin
                        dmem_be    = 4'b0001 << addr[1:0];
                        dmem_wdata = {4{st_data[7:0]}};
                    end
                    2'b01: begin
                        dmem_be    = addr[1] ? 4'b1100 : 4'b0011;
                        dmem_wdata = {2{st_data[15:0]}};
                    end
                    default: begin
                        dmem_be    = 4'b1111;
                        dmem_wdata = st_data;
                    end
                endcase
            end
            ack_hit            = dmem_req && dmem_ack;
            stall_MEM          = dmem_req && !dmem_ack;
            writeRegister1_MEM = cur[179:174];
            Data1_MEM          = is_load ? ld_ext : addr;
            do_writeback1_MEM  = !flush_fCOM && cur[140] && !mis &&
                                 (((state == S_IDLE) && !is_mem) ||
                                  ((state != S_DRAIN) && is_load && ack_hit));
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= S_IDLE;
            lat_entry    <= '0;
            ret_entry    <= '0;
            wait_cycles  <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            if (stall_MEM && (wait_cycles != {WAIT_CNT_W{1'b1}}))
                wait_cycles <= wait_cycles + 1'b1;

            case (state)
                S_IDLE: begin
                    if (flush_fCOM) begin
                        ret_entry <= '0;
                    end else if (mis) begin
                        ret_entry    <= RET_ENTRY_SIZE'(trap_entry);
                        misalign_err <= 1'b1;
                    end else if (!is_mem || dmem_ack) begin
                        ret_entry <= RET_ENTRY_SIZE'(done_entry);
                    end else begin
                        lat_entry <= mem_entry;
                        ret_entry <= '0;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dmem_ack) begin
                        ret_entry <= flush_fCOM ? '0 : RET_ENTRY_SIZE'(done_entry);
                        state     <= S_IDLE;
                    end else begin
                        ret_entry <= '0;
                        if (flush_fCOM) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // The access is already on the port; wait for it, discard the result.
                    ret_entry <= '0;
                    if (dmem_ack) state <= S_IDLE;
                end
                default: begin
                    ret_entry <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of the execute stage.
- Consumes the 320-bit mem_entry, performs loads and stores over a req/ack data-memory port, and produces ret_entry for retirement.
- Drives the MEM bypass triple (do_writeback1_MEM, writeRegister1_MEM, Data1_MEM) back to execute.
- Raises stall_MEM to freeze upstream while a memory access is outstanding.

Parameters:
- MEM_ENTRY_SIZE, 320, width of incoming entry.
- RET_ENTRY_SIZE, 320, width of outgoing entry.
- WAIT_CNT_W, 16, width of the saturating wait-cycle counter.

Ports:
- CLK  in  1  clock.
- RESET  in  1  asynchronous, active-low reset.
- mem_entry  in  MEM_ENTRY_SIZE  entry from execute.
- flush_fCOM  in  1  commit flush.
- dmem_ack  in  1  data memory acknowledge.
- dmem_rdata  in  32  load data, valid when dmem_ack=1.
- dmem_req  out  1  access request.
- dmem_we  out  1  1=store.
- dmem_addr  out  32  word-aligned address (low 2 bits zero).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- stall_MEM  out  1  freeze request to upstream.
- do_writeback1_MEM  out  1  bypass valid.
- writeRegister1_MEM  out  6  bypass register.
- Data1_MEM  out  32  bypass data.
- ret_entry  out  RET_ENTRY_SIZE  registered entry to retirement.
- wait_cycles  out  WAIT_CNT_W  saturating count of stall cycles.
- misalign_err  out  1  misaligned-access flag (only with the optional feature).

Behaviour:
- Entry fields:
  - [319:288] Dst
  - [287:256] store data
  - [255:224] OpB
  - [223:192] aluResult / effective address
  - [179:174] writeRegister
  - [140] do_writeback
  - [139] MemRead
  - [138] MemWrite
  - [136:135] size: 00 word, 01 half, 10 byte, 11 treated as word
  - [134] load sign-extend
- An entry is a memory op iff MemRead|MemWrite. MemRead and MemWrite both set is treated as a store.
- FSM states: IDLE, WAIT, DRAIN.
  - IDLE:
    - Non-memory op: Data1_MEM=aluResult; do_writeback1_MEM=[140]; ret_entry <= {Dst, store data, OpB, aluResult, entry[191:0]} at next edge. Latency 1.
    - Memory op: dmem_req=1 combinationally, fields driven from mem_entry.
    - Memory op with dmem_ack same cycle: completes with zero wait; stall_MEM=0; ret_entry loads at the edge.
    - Memory op without dmem_ack: latch the entry; go to WAIT; stall_MEM=1.
  - WAIT:
    - dmem_req and all dmem_* held from the latched copy. stall_MEM = !dmem_ack.
    - On dmem_ack: ret_entry loaded from the latched copy (load data replaces aluResult field [223:192]); go to IDLE.
  - DRAIN:
    - Entered on flush_fCOM while in WAIT without ack. Request held until dmem_ack; result discarded.
    - stall_MEM=1 until ack; do_writeback1_MEM=0; go to IDLE on ack.
    - A store already requested still completes to memory.
- Load data:
  - Byte lane selected by addr[1:0]; halfword lane by addr[1].
  - Extended to 32 bits: sign-extend iff [134], else zero-extend.
- Stores:
  - dmem_be: byte = 1<<addr[1:0]; half = addr[1]?1100:0011; word = 1111.
  - dmem_wdata: byte replicated ×4; half replicated ×2.
- Bypass:
  - do_writeback1_MEM=1 only when the current entry's result is valid this cycle: non-memory op with [140]=1, or load with dmem_ack=1 and [140]=1.
  - Stores never write back.
  - Data1_MEM is the final extended load data on a load ack.
- Flush: flush_fCOM in IDLE or at ack clears ret_entry to 0 at the edge and suppresses completion of the current entry.
- Reset: all outputs 0, state IDLE, wait_cycles=0. Reset during WAIT or DRAIN abandons the transaction and dmem_req drops immediately.
- Counter: wait_cycles increments on every edge where stall_MEM=1 and saturates at all-ones.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, issues no dmem_req. ret_entry bit [141] is set, writeback is suppressed, and misalign_err pulses for 1 cycle. Latency 1.
- When undefined: the low address bits are ignored for word access (and addr[0] for half), the access proceeds, and misalign_err is tied 0.

Test Plan:
- ALU entry, aluResult=0x1234, wr=5, wb=1 → Data1_MEM=0x1234, do_writeback1_MEM=1 same cycle; ret_entry[223:192]=0x1234 next edge; stall_MEM=0.
- Load byte, addr=0x103, signed, ack after 3 cycles with rdata=0x80FFFFFF → dmem_be=1000; stall_MEM high for 3 cycles; Data1_MEM=0xFFFFFF80 on the ack cycle; wait_cycles=3.
- Store half, addr=0x202, data=0xABCD, ack same cycle → dmem_addr=0x200, be=1100, wdata=0xABCDABCD, we=1, no stall, do_writeback1_MEM=0.
- Load in WAIT, flush_fCOM pulse, ack 2 cycles later → DRAIN; stall_MEM=1 until ack; ret_entry=0; no writeback.
- RESET low during WAIT → dmem_req=0 and stall_MEM=0 immediately; after release, a new ALU entry completes normally.
- With MEM_MISALIGN_TRAP_EN: word load at addr=0x6 → no dmem_req, misalign_err=1 for one cycle, ret_entry[141]=1.
